// File: rtl/vram_stream_pkg.sv
// vram_stream_pkg: states and byte-layout constants shared by the TX streamer and the RX packer
package vram_stream_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_RDY, HDR_HI, HDR_LO, PAYLOAD, GAP} state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_PIXEL = 3;
endpackage

// File: rtl/pix_serializer.sv
// pix_serializer: picks the R/G/B byte of a pixel; byte 0 comes straight from the RAM, later bytes from the hold copy
module pix_serializer (
  input  logic [23:0] hold,
  input  logic [23:0] fresh,
  input  logic [1:0]  idx,
  output logic [7:0]  pix_byte,
  output logic        need_next
);
  logic [23:0] pix;
  // R byte starts a new pixel, so it must bypass the hold register
  always_comb begin
    need_next = idx == 2'd0;
    pix = need_next ? fresh : hold;
    pix_byte = idx == 2'd0 ? pix[23:16] : idx == 2'd1 ? pix[15:8] : pix[7:0];
  end
endmodule

// File: rtl/vram2stream.sv
// vram2stream: reads frame VRAM and emits header+RGB byte packets for the Ethernet TX MAC
module vram2stream
  import vram_stream_pkg::*;
#(
  parameter int FRAME_PIXELS = 19200,
  parameter int PKT_PIXELS = 160,
  parameter int GAP_CYCLES = 12
) (
  input  logic        clk,
  input  logic        xrst,
  input  logic        start,
  input  logic        tx_ready,
  output logic [15:0] ram_addr,
  input  logic [23:0] ram_din,
  output logic [7:0]  data_out,
  output logic        data_en,
  output logic        busy,
  output logic        frame_done
);
  localparam logic [16:0] FRAME = 17'(FRAME_PIXELS);
  localparam logic [16:0] PKT = 17'(PKT_PIXELS);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  state_t state, nxt;
  logic [16:0] pkt_base, base_n, pix, pix_n, rem, pkt_end, pix_inc;
  logic [1:0] bidx, bidx_n, nidx;
  logic [31:0] gap, gap_n;
  logic [23:0] hold, hold_n;
  logic [15:0] addr_n;
  logic [7:0] out_n, ser_byte;
  logic en_n, busy_n, done_n, ser_new, pkt_last, leave;

  pix_serializer u_ser (
    .hold(hold),
    .fresh(ram_din),
    .idx(nidx),
    .pix_byte(ser_byte),
    .need_next(ser_new)
  );

  // Packet extent (17-bit so a 65536-pixel frame ends cleanly) and next byte index
  always_comb begin
    rem = FRAME - pkt_base;
    pkt_end = pkt_base + (rem < PKT ? rem : PKT);
    pix_inc = pix + 17'd1;
    pkt_last = bidx == LAST_BYTE && pix_inc == pkt_end;
    nidx = state == PAYLOAD && bidx != LAST_BYTE ? bidx + 2'd1 : 2'd0;
  end

  // Packet FSM; the address is always pkt_base from WAIT_RDY, and the next pixel is fetched during G so R follows B
  always_comb begin
    nxt = state;
    base_n = pkt_base;
    pix_n = pix;
    bidx_n = bidx;
    gap_n = gap;
    hold_n = hold;
    addr_n = ram_addr;
    out_n = 8'd0;
    en_n = 1'b0;
    busy_n = busy;
    done_n = 1'b0;
    leave = 1'b0;
    case (state)
      IDLE: if (start) begin
        nxt = WAIT_RDY;
        busy_n = 1'b1;
        base_n = 17'd0;
        addr_n = 16'd0;
      end
      WAIT_RDY: if (tx_ready) begin
        nxt = HDR_HI;
        en_n = 1'b1;
        out_n = pkt_base[15:8];
      end
      HDR_HI: begin
        nxt = HDR_LO;
        en_n = 1'b1;
        out_n = pkt_base[7:0];
        pix_n = pkt_base;
      end
      HDR_LO, PAYLOAD: if (state == PAYLOAD && pkt_last) begin
        nxt = GAP;
        base_n = pkt_end;
        gap_n = 32'd1;
        leave = GAP_CYCLES == 1;
      end else begin
        nxt = PAYLOAD;
        en_n = 1'b1;
        out_n = ser_byte;
        bidx_n = nidx;
        if (ser_new) begin
          hold_n = ram_din;
          pix_n = state == PAYLOAD ? pix_inc : pix;
        end
        if (nidx == 2'd1 && pix_inc < pkt_end) addr_n = pix_inc[15:0];
      end
      GAP: if (gap == GAP_LAST) leave = 1'b1;
        else gap_n = gap + 32'd1;
      default: nxt = IDLE;
    endcase
    if (leave) begin
      if (base_n < FRAME) begin
        nxt = WAIT_RDY;
        addr_n = base_n[15:0];
      end else begin
        nxt = IDLE;
        busy_n = 1'b0;
        done_n = 1'b1;
      end
    end
  end

  // State, counters and registered outputs; reset aborts any packet at once
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      state <= IDLE;
      pkt_base <= '0;
      pix <= '0;
      bidx <= '0;
      gap <= '0;
      hold <= '0;
      ram_addr <= '0;
      data_out <= '0;
      data_en <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt;
      pkt_base <= base_n;
      pix <= pix_n;
      bidx <= bidx_n;
      gap <= gap_n;
      hold <= hold_n;
      ram_addr <= addr_n;
      data_out <= out_n;
      data_en <= en_n;
      busy <= busy_n;
      frame_done <= done_n;
    end
endmodule

// File: tb/tb_vram2stream.sv
// tb_vram2stream: stream model plus literal frame checks for vram2stream
module tb_vram2stream;
  localparam int FP = 8, PP = 3, GC = 2;
  logic clk = 0, xrst = 0, start = 0, tx_ready = 0, start6 = 0;
  logic [15:0] ram_addr, addr6;
  logic [23:0] ram_din = '0, din6 = '0;
  logic [7:0] data_out, d6;
  logic data_en, busy, frame_done, en6, busy6, fd6;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vram2stream #(.FRAME_PIXELS(FP), .PKT_PIXELS(PP), .GAP_CYCLES(GC)) dut (
    .clk(clk), .xrst(xrst), .start(start), .tx_ready(tx_ready), .ram_addr(ram_addr),
    .ram_din(ram_din), .data_out(data_out), .data_en(data_en), .busy(busy), .frame_done(frame_done));

  vram2stream #(.FRAME_PIXELS(4), .PKT_PIXELS(4), .GAP_CYCLES(2)) dut6 (
    .clk(clk), .xrst(xrst), .start(start6), .tx_ready(1'b1), .ram_addr(addr6),
    .ram_din(din6), .data_out(d6), .data_en(en6), .busy(busy6), .frame_done(fd6));

  function automatic logic [23:0] pixel(input logic [15:0] a);
    pixel = {a[7:0], a[7:0] + 8'h40, a[7:0] + 8'h80};
  endfunction

  // One-cycle-latency VRAM models
  always @(posedge clk) begin
    ram_din <= pixel(ram_addr);
    din6 <= pixel(addr6);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queue of expected bytes per packet, gap counting, ready/start sampling
  logic [7:0] q[$];
  int next_base = 0, idle = 0;
  bit m_busy = 0, armed = 0, in_gap = 0;
  always @(posedge clk) begin : model
    logic s_rst, s_start, s_rdy, exp_en, exp_fd;
    logic [7:0] exp_d;
    logic [23:0] p;
    int n;
    s_rst = xrst;
    s_start = start;
    s_rdy = tx_ready;
    #1;
    exp_en = 0;
    exp_d = 0;
    exp_fd = 0;
    if (!s_rst) begin
      q.delete();
      m_busy = 0;
      armed = 0;
      in_gap = 0;
    end else if (q.size() != 0) begin
      exp_en = 1;
      exp_d = q.pop_front();
      if (q.size() == 0) begin
        in_gap = 1;
        idle = 0;
      end
    end else if (armed) begin
      if (s_rdy) begin
        armed = 0;
        n = (FP - next_base < PP) ? FP - next_base : PP;
        q.push_back(8'(next_base >> 8));
        q.push_back(8'(next_base));
        for (int i = 0; i < n; i++) begin
          p = pixel(16'(next_base + i));
          q.push_back(p[23:16]);
          q.push_back(p[15:8]);
          q.push_back(p[7:0]);
        end
        next_base += n;
        exp_en = 1;
        exp_d = q.pop_front();
      end
    end else if (in_gap) begin
      idle++;
      if (idle == GC) begin
        in_gap = 0;
        if (next_base < FP) armed = 1;
        else begin
          m_busy = 0;
          exp_fd = 1;
        end
      end
    end else if (!m_busy && s_start) begin
      m_busy = 1;
      armed = 1;
      next_base = 0;
    end
    chk("m_data_en", data_en, exp_en);
    chk("m_data_out", data_out, exp_d);
    chk("m_busy", busy, m_busy);
    chk("m_frame_done", frame_done, exp_fd);
    chk("m_addr_range", ram_addr < FP, 1);
  end

  task automatic wait_en(input logic lvl, input string name);
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (data_en !== lvl && k < 200);
    chk(name, data_en, lvl);
    #1;
  endtask

  task automatic wait_fd(input string name);
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (frame_done !== 1'b1 && k < 300);
    chk(name, frame_done, 1);
    #1;
  endtask

  // Full frame with tx_ready held high, checked against hand-computed literals
  task automatic frame_lit(input string tag);
    int runs[$], gaps[$];
    logic [7:0] b[$];
    int cur = 0, idl = 0, fds = 0, cyc = 0;
    bit seen = 0;
    int exp_runs[3] = '{11, 11, 8};
    logic [7:0] p0[11] = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h80, 8'h01, 8'h41, 8'h81, 8'h02, 8'h42, 8'h82};
    start = 1;
    @(posedge clk); #2 start = 0;
    while (fds == 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (data_en) begin
        if (cur == 0 && seen) gaps.push_back(idl);
        cur++;
        b.push_back(data_out);
        seen = 1;
        idl = 0;
      end else begin
        if (cur != 0) runs.push_back(cur);
        cur = 0;
        idl++;
      end
      if (frame_done) fds++;
      #1;
    end
    chk({tag, "_frame_done"}, fds, 1);
    chk({tag, "_run_count"}, runs.size(), 3);
    while (runs.size() < 3) runs.push_back(0);
    while (gaps.size() < 2) gaps.push_back(0);
    while (b.size() < 30) b.push_back(8'hee);
    for (int i = 0; i < 3; i++) chk($sformatf("%s_run%0d_len", tag, i), runs[i], exp_runs[i]);
    for (int i = 0; i < 2; i++) chk($sformatf("%s_gap%0d", tag, i), gaps[i], GC);
    chk({tag, "_tail_idle"}, idl, GC);
    for (int i = 0; i < 11; i++) chk($sformatf("%s_pkt0_byte%0d", tag, i), b[i], p0[i]);
    chk({tag, "_hdr1"}, {b[11], b[12]}, 16'h0003);
    chk({tag, "_hdr2"}, {b[22], b[23]}, 16'h0006);
    chk({tag, "_last_pixel"}, {b[27], b[28], b[29]}, 24'h074787);
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_single"}, frame_done, 0);
    #1;
  endtask

  initial begin
    logic [7:0] b6[$];
    logic [7:0] e6[14] = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h80, 8'h01, 8'h41, 8'h81,
                           8'h02, 8'h42, 8'h82, 8'h03, 8'h43, 8'h83};
    int mx, bad, len, runs, fds, k;
    bit prev_en, fd6_seen;
    #7;
    chk("rst_data_en", data_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_data_out", data_out, 0);
    @(posedge clk); #2;
    xrst = 1;
    tx_ready = 1;
    // Single full-frame packet on the 4-pixel instance
    start6 = 1;
    @(posedge clk); #2 start6 = 0;
    mx = 0;
    fd6_seen = 0;
    k = 0;
    while (!fd6_seen && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (en6) b6.push_back(d6);
      if (int'(addr6) > mx) mx = int'(addr6);
      if (fd6) fd6_seen = 1;
      #1;
    end
    chk("s6_done", fd6_seen, 1);
    chk("s6_len", b6.size(), 14);
    while (b6.size() < 14) b6.push_back(8'hee);
    for (int i = 0; i < 14; i++) chk($sformatf("s6_byte%0d", i), b6[i], e6[i]);
    chk("s6_addr_peak", mx, 3);
    // Basic frame
    frame_lit("s1");
    // tx_ready withheld after the first gap, then dropped mid-packet
    start = 1;
    @(posedge clk); #2 start = 0;
    wait_en(1, "s3_run0");
    wait_en(0, "s3_gap0");
    tx_ready = 0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (data_en || !busy) bad++;
      #1;
    end
    chk("s3_stall", bad, 0);
    tx_ready = 1;
    @(posedge clk); #1;
    chk("s3_hdr_latency", data_en, 1);
    chk("s3_hdr_hi", data_out, 8'h00);
    #1 tx_ready = 0;
    @(posedge clk); #1;
    chk("s3_hdr_lo", data_out, 8'h03);
    len = 2;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (data_en) len++;
    end while (data_en && k < 50);
    chk("s3_run1_len", len, 11);
    #1 tx_ready = 1;
    wait_fd("s3_done");
    // start during a packet is ignored; start right after frame_done is honoured
    start = 1;
    @(posedge clk); #2 start = 0;
    wait_en(1, "s4_run0");
    wait_en(0, "s4_gap0");
    wait_en(1, "s4_run1");
    start = 1;
    @(posedge clk); #2 start = 0;
    runs = 2;
    fds = 0;
    prev_en = 1;
    k = 0;
    while (fds == 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (data_en && !prev_en) runs++;
      prev_en = data_en;
      if (frame_done) fds++;
      #1;
    end
    chk("s4_runs", runs, 3);
    chk("s4_done", fds, 1);
    @(posedge clk); #1;
    chk("s4_not_queued", busy, 0);
    #1 start = 1;
    @(posedge clk); #2 start = 0;
    wait_en(1, "s4_restart");
    chk("s4_restart_hdr_hi", data_out, 8'h00);
    @(posedge clk); #1;
    chk("s4_restart_hdr_lo", {data_en, data_out}, 9'h100);
    #1;
    wait_fd("s4_restart_done");
    // Asynchronous reset in the middle of packet 1
    start = 1;
    @(posedge clk); #2 start = 0;
    wait_en(1, "s5_run0");
    wait_en(0, "s5_gap0");
    wait_en(1, "s5_run1");
    repeat (7) @(posedge clk);
    #3;
    chk("s5_pre_en", data_en, 1);
    xrst = 0;
    #1;
    chk("s5_async_en", data_en, 0);
    chk("s5_async_busy", busy, 0);
    chk("s5_async_out", data_out, 0);
    chk("s5_async_addr", ram_addr, 0);
    chk("s5_async_done", frame_done, 0);
    @(posedge clk);
    @(posedge clk); #2;
    xrst = 1;
    frame_lit("s5");
    // Randomised ready, start and reset traffic against the model
    repeat (4000) begin
      @(posedge clk); #2;
      tx_ready = $urandom_range(0, 3) != 0;
      start = $urandom_range(0, 19) == 0;
      xrst = $urandom_range(0, 499) != 0;
    end
    @(posedge clk); #2;
    xrst = 1;
    start = 0;
    tx_ready = 1;
    repeat (80) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
